// File: rtl/iir_sm_accumulator.sv
// Sign-magnitude Q7.8 saturating accumulator: sums NTERMS product terms per frame and
// delivers one saturated sample over valid/ready. Optional sticky overflow flag: ACC_OVF_STICKY_EN.
module iir_sm_accumulator #(
  parameter int NTERMS = 5,
  parameter int ACC_W  = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        termValid,
  output logic        termReady,
  input  logic [15:0] term,
  input  logic        termSub,
  output logic        sumValid,
  input  logic        sumReady,
  output logic [15:0] sum,
  output logic        overflow
`ifdef ACC_OVF_STICKY_EN
  ,
  input  logic        ovfClear,
  output logic        ovfSticky
`endif
);

  localparam int CNT_W = (NTERMS > 1) ? $clog2(NTERMS) : 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                   state, state_nxt;
  logic [CNT_W-1:0]         count;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  mag_ext, contrib, final_sum;
  logic [ACC_W-1:0]         final_abs;
  logic                     accept, last, final_neg, sat;
  logic [15:0]              sum_nxt;

  assign accept  = termValid & termReady;
  assign last    = (count == CNT_W'(NTERMS - 1));

  // Magnitude 0 negates to 0, so a negative-zero term is harmless.
  assign mag_ext   = signed'({{(ACC_W-15){1'b0}}, term[14:0]});
  assign contrib   = (term[15] ^ termSub) ? -mag_ext : mag_ext;
  assign final_sum = acc + contrib;

  // Any magnitude bit at or above 2^15 means the result does not fit; this also catches -32768.
  assign final_neg = final_sum[ACC_W-1];
  assign final_abs = final_neg ? unsigned'(-final_sum) : unsigned'(final_sum);
  assign sat       = |final_abs[ACC_W-1:15];
  assign sum_nxt   = sat ? {final_neg, 15'h7FFF} : {final_neg, final_abs[14:0]};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  // NOTE: defaulting every comb output first keeps unlisted paths from inferring latches.
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (accept && last)       state_nxt = HOLD;
      HOLD:    if (sumValid && sumReady) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_comb begin
    termReady = 1'b0;
    sumValid  = 1'b0;
    case (state)
      ACCUM:   termReady = 1'b1;
      HOLD:    sumValid  = 1'b1;
      default: termReady = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      count    <= '0;
      sum      <= 16'h0000;
      overflow <= 1'b0;
    end else if (accept) begin
      if (last) begin
        acc      <= '0;
        count    <= '0;
        sum      <= sum_nxt;
        overflow <= sat;
      end else begin
        acc   <= final_sum;
        count <= count + CNT_W'(1);
      end
    end
  end

`ifdef ACC_OVF_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     ovfSticky <= 1'b0;
    else if (accept && last && sat) ovfSticky <= 1'b1;
    else if (ovfClear)              ovfSticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_iir_sm_accumulator.sv
// Scoreboard bench for iir_sm_accumulator: a frame-level integer model pushes expected samples,
// a monitor pops and compares on every sum handshake.
module tb_iir_sm_accumulator;

  localparam int NTERMS = 5;
  localparam int ACC_W  = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        termValid = 1'b0;
  logic        termReady;
  logic [15:0] term = 16'h0;
  logic        termSub = 1'b0;
  logic        sumValid;
  logic        sumReady = 1'b1;
  logic [15:0] sum;
  logic        overflow;
`ifdef ACC_OVF_STICKY_EN
  logic        ovfClear = 1'b0;
  logic        ovfSticky;
`endif

  iir_sm_accumulator #(.NTERMS(NTERMS), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .termValid(termValid), .termReady(termReady), .term(term), .termSub(termSub),
    .sumValid(sumValid), .sumReady(sumReady), .sum(sum), .overflow(overflow)
`ifdef ACC_OVF_STICKY_EN
    , .ovfClear(ovfClear), .ovfSticky(ovfSticky)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [16:0] expq[$];
  int model_total = 0;
  int model_n = 0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference: plain integer sum, saturated once at the end of the frame.
  task automatic model_term(input logic [15:0] t, input logic s);
    int v;
    logic [16:0] e;
    int a;
    v = int'(t[14:0]);
    model_total += (t[15] ^ s) ? -v : v;
    model_n++;
    if (model_n == NTERMS) begin
      if (model_total > 32767)       e = {16'h7FFF, 1'b1};
      else if (model_total < -32767) e = {16'hFFFF, 1'b1};
      else begin
        a = (model_total < 0) ? -model_total : model_total;
        e = {(model_total < 0), a[14:0], 1'b0};
      end
      expq.push_back(e);
      model_total = 0;
      model_n = 0;
    end
  endtask

  // Assumes termValid/term/termSub already driven; returns at posedge+1 after the accept.
  task automatic wait_accept();
    bit rdy;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = termReady;
      @(posedge clk);
      if (rdy) begin
        #1;
        model_term(term, termSub);
        termValid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'd1, 32'd0);
    #1 termValid = 1'b0;
  endtask

  task automatic send_term(input logic [15:0] t, input logic s);
    termValid = 1'b1;
    term = t;
    termSub = s;
    wait_accept();
  endtask

  task automatic send_frame(input logic [15:0] t);
    for (int i = 0; i < NTERMS; i++) send_term(t, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && expq.size() != 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", expq.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [16:0] e;
    if (rst_n && sumValid && sumReady) begin
      if (expq.size() == 0) check("unexpected_sum", 32'd1, 32'd0);
      else begin
        e = expq.pop_front();
        check("sum", sum, e[16:1]);
        check("overflow", overflow, e[0]);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) sumReady = 1'($urandom_range(0, 1));
  end

  initial begin
    logic [15:0] t;
    #1;
    check("rst_termReady", termReady, 1);
    check("rst_sumValid", sumValid, 0);
    check("rst_sum", sum, 16'h0000);
    check("rst_overflow", overflow, 0);
`ifdef ACC_OVF_STICKY_EN
    check("rst_ovfSticky", ovfSticky, 0);
`endif
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Five unit terms, latency one cycle.
    for (int i = 0; i < NTERMS - 1; i++) send_term(16'h0100, 1'b0);
    check("latency_before", sumValid, 0);
    send_term(16'h0100, 1'b0);
    check("latency_after", sumValid, 1);
    drain();

    // Mixed signs and subtraction: 256+640-128-64+32 = 736.
    send_term(16'h0100, 1'b0);
    send_term(16'h0280, 1'b0);
    send_term(16'h8080, 1'b0);
    send_term(16'h0040, 1'b1);
    send_term(16'h8020, 1'b1);
    drain();

    send_frame(16'h7000);
`ifdef ACC_OVF_STICKY_EN
    check("sticky_set", ovfSticky, 1);
`endif
    send_frame(16'hF000);
    send_frame(16'h8000);
    drain();
`ifdef ACC_OVF_STICKY_EN
    check("sticky_hold", ovfSticky, 1);
    ovfClear = 1'b1;
    @(posedge clk); #1 ovfClear = 1'b0;
    check("sticky_clear", ovfSticky, 0);
`endif

    // Backpressure with a term held on the input.
    sumReady = 1'b0;
    send_frame(16'h0100);
    termValid = 1'b1; term = 16'h0100; termSub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_termReady", termReady, 0);
      check("bp_sumValid", sumValid, 1);
      check("bp_sum_stable", sum, 16'h0500);
    end
    @(posedge clk); #1 sumReady = 1'b1;
    wait_accept();
    for (int i = 0; i < NTERMS - 1; i++) send_term(16'h0100, 1'b0);
    drain();

    // Reset mid-frame discards the partial sum.
    send_term(16'h0400, 1'b0);
    send_term(16'h0400, 1'b0);
    rst_n = 1'b0;
    model_total = 0;
    model_n = 0;
    #1;
    check("mid_rst_termReady", termReady, 1);
    check("mid_rst_sumValid", sumValid, 0);
    check("mid_rst_sum", sum, 16'h0000);
    check("mid_rst_overflow", overflow, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    send_frame(16'h0100);
    drain();

    // Randomized frames with random backpressure and idle gaps.
    rand_ready = 1'b1;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < NTERMS; i++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        t = 16'($urandom);
        if ($urandom_range(0, 1) == 1) t[14:12] = 3'b000;
        send_term(t, 1'($urandom_range(0, 1)));
      end
    end
    rand_ready = 1'b0;
    sumReady = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iir_sm_accumulator.md
Name: iir_sm_accumulator

Overview:
Sign-magnitude Q7.8 saturating accumulator that sits directly downstream of the 16-bit sign-magnitude multiplier in the IIR filter datapath. It consumes one product term per handshake and sums NTERMS terms per output sample. Feedback terms can be subtracted. It delivers one saturated sign-magnitude Q7.8 sample per frame over a valid/ready interface.

Parameters:
NTERMS, 5, product terms per output sample (biquad: b0,b1,b2,a1,a2); legal range 1..2^(ACC_W-16)
ACC_W, 20, internal two's-complement accumulator width (guard bits against intermediate wrap)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
termValid  input  1  term/termSub valid
termReady  output  1  block accepts a term this cycle
term  input  16  product, sign-magnitude Q7.8 (bit15 sign, [14:0] magnitude)
termSub  input  1  1 = subtract this term (feedback coefficient)
sumValid  output  1  sum valid
sumReady  input  1  downstream accepts sum
sum  output  16  accumulated sample, sign-magnitude Q7.8
overflow  output  1  frame saturated; qualified by sumValid

Behaviour:
- Clock and reset: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values: state=ACCUM, acc=0, count=0, sum=0x0000, sumValid=0, overflow=0. termReady=1 (decoded from state).
- States:
  - ACCUM: termReady=1, sumValid=0.
  - HOLD: termReady=0, sumValid=1.
- Term acceptance:
  - Term accepted when termValid & termReady.
  - Effective sign = term[15]^termSub.
  - Contribution = zero-extended term[14:0], negated if effective sign=1.
  - Magnitude 0 contributes 0 regardless of sign (negative zero harmless).
- ACCUM, accept with count<NTERMS-1: acc<=acc+contribution; count<=count+1.
- ACCUM, accept with count==NTERMS-1:
  - final=acc+contribution, saturated and registered into sum/overflow.
  - acc<=0, count<=0, go to HOLD.
  - sumValid rises the cycle after the last accept (latency 1).
- Saturation of final:
  - final>32767 -> sum=0x7FFF, overflow=1.
  - final<-32767 -> sum=0xFFFF, overflow=1 (-32768 also saturates).
  - Otherwise sum={final<0, |final|[14:0]}, overflow=0.
  - Zero result is always 0x0000, never 0x8000.
- HOLD:
  - sum/overflow stable until sumValid & sumReady.
  - On that handshake go to ACCUM; termReady=1 the next cycle.
  - Terms presented during HOLD are not accepted.
- NTERMS=1: every accepted term goes straight to HOLD.
- Intermediate accumulation never wraps within the legal NTERMS range. No saturation is applied until the final term.
- Reset mid-frame: partial acc/count discarded immediately. The next frame starts from zero.
- termValid without a handshake leaves state unchanged. No combinational path from termValid to termReady.

Optional Feature:
ACC_OVF_STICKY_EN
- Defined:
  - Adds input ovfClear (1 bit) and output ovfSticky (1 bit).
  - ovfSticky sets on any frame that saturates (same cycle overflow is registered).
  - ovfSticky holds until ovfClear=1 at a clock edge or reset; reset value 0.
  - Set wins over a simultaneous clear.
- Not defined: ports absent; behaviour otherwise identical.

Test Plan:
- Five terms 0x0100, termSub=0, sumReady=1 -> sumValid one cycle after 5th accept; sum=0x0500, overflow=0.
- Terms {0x0100/0, 0x0280/0, 0x8080/0, 0x0040/1, 0x8020/1} (term/termSub) -> sum=0x02E0 (736), overflow=0.
- Five terms 0x7000 -> sum=0x7FFF, overflow=1. Five terms 0xF000 -> sum=0xFFFF, overflow=1. With ACC_OVF_STICKY_EN: ovfSticky=1 until ovfClear pulse.
- Five terms 0x8000 (negative zero) -> sum=0x0000.
- Backpressure: sumReady=0 for 3 cycles after sumValid, termValid held high with 0x0100 -> termReady=0, sum stable. Frame completes on sumReady=1. The next frame then accepts the held term, and its sum is 0x0500.
- Assert rst_n=0 after 2 accepted terms of 0x0400 mid-frame -> all outputs at reset values. After release, five terms 0x0100 -> sum=0x0500.
